// File: rtl/mod14_wrap_tracker.sv
// Wrap/direction tracker for a mod-14 counter: flags wraps, illegal values and jumps, and keeps a saturating revolution count.
// Define MOD14_TRK_JUMP_FAULT_EN to make a jump fatal (FAULT) instead of a resynchronisation to STILL.
module mod14_wrap_tracker (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] count_out,
    output logic       up_wrap,
    output logic       down_wrap,
    output logic       illegal,
    output logic       jump,
    output logic [2:0] state,
    output logic [7:0] rev_cnt,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_STILL = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_FAULT = 3'd4
    } trk_state_e;

    localparam logic [3:0] MAX_VAL = 4'd13;
    localparam logic [7:0] REV_MAX = 8'h7F;
    localparam logic [7:0] REV_MIN = 8'h80;

    trk_state_e state_q, state_d;
    logic [3:0] prev_q;
    logic [7:0] rev_q, rev_d;
    logic       up_wrap_q, down_wrap_q, illegal_q, jump_q;
    logic       up_wrap_d, down_wrap_d, illegal_d, jump_d;

    logic       sample_ok, prev_ok, tracking;
    logic       is_hold, is_step_up, is_step_down, is_jump;
    logic [3:0] prev_inc, prev_dec;

    // Pair classification; only meaningful while actively tracking a legal history.
    always_comb begin
        sample_ok    = (count_out <= MAX_VAL);
        prev_ok      = (prev_q <= MAX_VAL);
        prev_inc     = (prev_q == MAX_VAL) ? 4'd0 : prev_q + 4'd1;
        prev_dec     = (prev_q == 4'd0) ? MAX_VAL : prev_q - 4'd1;
        tracking     = sample_ok && prev_ok &&
                       ((state_q == ST_STILL) || (state_q == ST_UP) || (state_q == ST_DOWN));
        is_hold      = tracking && (count_out == prev_q);
        is_step_up   = tracking && (count_out == prev_inc);
        is_step_down = tracking && (count_out == prev_dec);
        is_jump      = tracking && !is_hold && !is_step_up && !is_step_down;
    end

    // State register; prev always follows the sample, including on clear.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            prev_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            prev_q  <= count_out;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path through the combinational block infers a latch.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:  state_d = sample_ok ? ST_STILL : ST_FAULT;
                ST_STILL, ST_UP, ST_DOWN: begin
                    if (!sample_ok)        state_d = ST_FAULT;
                    else if (!prev_ok)     state_d = ST_STILL;
                    else if (is_hold)      state_d = ST_STILL;
                    else if (is_step_up)   state_d = ST_UP;
                    else if (is_step_down) state_d = ST_DOWN;
                    else begin
`ifdef MOD14_TRK_JUMP_FAULT_EN
                        state_d = ST_FAULT;
`else
                        state_d = ST_STILL;
`endif
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    // Output logic: pulse and revolution-count next values.
    always_comb begin
        up_wrap_d   = !clear && is_step_up && (prev_q == MAX_VAL);
        down_wrap_d = !clear && is_step_down && (prev_q == 4'd0);
        illegal_d   = !clear && !sample_ok;
        jump_d      = !clear && is_jump;
        rev_d       = rev_q;
        if (clear) begin
            rev_d = 8'h00;
        end else if (state_q != ST_FAULT) begin
            if (up_wrap_d && (rev_q != REV_MAX))
                rev_d = rev_q + 8'd1;
            else if (down_wrap_d && (rev_q != REV_MIN))
                rev_d = rev_q - 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up_wrap_q   <= 1'b0;
            down_wrap_q <= 1'b0;
            illegal_q   <= 1'b0;
            jump_q      <= 1'b0;
            rev_q       <= 8'h00;
        end else begin
            up_wrap_q   <= up_wrap_d;
            down_wrap_q <= down_wrap_d;
            illegal_q   <= illegal_d;
            jump_q      <= jump_d;
            rev_q       <= rev_d;
        end
    end

    assign up_wrap   = up_wrap_q;
    assign down_wrap = down_wrap_q;
    assign illegal   = illegal_q;
    assign jump      = jump_q;
    assign state     = state_q;
    assign rev_cnt   = rev_q;
    assign fault     = (state_q == ST_FAULT);

endmodule
